// File: rtl/alu_seq16.sv
// alu_seq16: operand sequencer and flag register in front of an 8-bit ALU.
// Accepts 8/16-bit requests, runs one or two byte passes through the ALU with
// the carry chained between passes, and holds the result and flag byte.
module alu_seq16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is16,
    input  logic [3:0]  in_f,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        ld_flags,
    input  logic [7:0]  flags_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_d,
    output logic        out_err,
    output logic [7:0]  flags,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    output logic [3:0]  alu_f,
    input  logic [7:0]  alu_d,
    input  logic        alu_s,
    input  logic        alu_z,
    input  logic        alu_h,
    input  logic        alu_pv,
    input  logic        alu_n,
    input  logic        alu_c
);

    localparam logic [3:0] F_MOV  = 4'd0;
    localparam logic [3:0] F_INC  = 4'd1;
    localparam logic [3:0] F_INCC = 4'd2;
    localparam logic [3:0] F_DEC  = 4'd3;
    localparam logic [3:0] F_DECC = 4'd4;
    localparam logic [3:0] F_ADD  = 4'd5;
    localparam logic [3:0] F_ADC  = 4'd6;
    localparam logic [3:0] F_SUB  = 4'd7;
    localparam logic [3:0] F_SBC  = 4'd8;
    localparam logic [3:0] F_RR   = 4'd12;
    localparam logic [3:0] F_RRC  = 4'd14;
    localparam logic [3:0] F_RLC  = 4'd15;

    // Flag byte layout {S,Z,0,H,0,PV,N,C}; bits 5 and 3 never stored as 1.
    localparam logic [7:0] FLAG_MASK = 8'hD7;

    typedef enum logic [1:0] {IDLE, P1, P2, DONE} state_t;

    state_t      state;
    logic        is16_q;
    logic [3:0]  f_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        cin_q;

    // First-pass results kept for the second pass and the final flag merge.
    logic [7:0]  t_d;
    logic        t_c;
    logic        t_z;
    logic        t_s;
    logic        t_h;
    logic        t_pv;
    logic        t_n;

    logic        hi_first;
    logic [3:0]  f_p2;

    // 16-bit RR shifts right, so the carry must travel from the high byte down.
    assign hi_first  = is16_q && (f_q == F_RR);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Second pass switches plain ops to their carry-chained variants.
    always_comb begin
        f_p2 = f_q;
        case (f_q)
            F_ADD:   f_p2 = F_ADC;
            F_INC:   f_p2 = F_INCC;
            F_DEC:   f_p2 = F_DECC;
            F_SUB:   f_p2 = F_SBC;
            default: f_p2 = f_q;
        endcase
    end

    // ALU operand/function drive, idle values outside the two pass states.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        alu_f   = F_MOV;
        case (state)
            P1: begin
                alu_a   = hi_first ? a_q[15:8] : a_q[7:0];
                alu_b   = hi_first ? b_q[15:8] : b_q[7:0];
                alu_cin = cin_q;
                alu_f   = f_q;
            end
            P2: begin
                alu_a   = hi_first ? a_q[7:0] : a_q[15:8];
                alu_b   = hi_first ? b_q[7:0] : b_q[15:8];
                alu_cin = t_c;
                alu_f   = f_p2;
            end
            default: ;
        endcase
    end

    // Sequencer FSM with request latch, pass capture, result and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            is16_q  <= 1'b0;
            f_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            t_d     <= '0;
            t_c     <= 1'b0;
            t_z     <= 1'b0;
            t_s     <= 1'b0;
            t_h     <= 1'b0;
            t_pv    <= 1'b0;
            t_n     <= 1'b0;
            out_d   <= '0;
            out_err <= 1'b0;
            flags   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_flags)
                        flags <= flags_in & FLAG_MASK;
                    if (in_valid) begin
                        is16_q <= in_is16;
                        f_q    <= in_f;
                        a_q    <= in_a;
                        b_q    <= in_b;
                        cin_q  <= ld_flags ? flags_in[0] : flags[0];
                        if (in_is16 && ((in_f == F_RRC) || (in_f == F_RLC))) begin
                            out_d   <= in_a;
                            out_err <= 1'b1;
                            state   <= DONE;
                        end else begin
                            out_err <= 1'b0;
                            state   <= P1;
                        end
                    end
                end
                P1: begin
                    t_d  <= alu_d;
                    t_c  <= alu_c;
                    t_z  <= alu_z;
                    t_s  <= alu_s;
                    t_h  <= alu_h;
                    t_pv <= alu_pv;
                    t_n  <= alu_n;
                    if (!is16_q) begin
                        out_d <= {8'h00, alu_d};
                        flags <= {alu_s, alu_z, 1'b0, alu_h, 1'b0, alu_pv, alu_n, alu_c};
                        state <= DONE;
                    end else begin
                        state <= P2;
                    end
                end
                P2: begin
                    // S/H/PV/N come from whichever pass handled the high byte.
                    if (hi_first) begin
                        out_d <= {t_d, alu_d};
                        flags <= {t_s, t_z & alu_z, 1'b0, t_h, 1'b0, t_pv, t_n, alu_c};
                    end else begin
                        out_d <= {alu_d, t_d};
                        flags <= {alu_s, t_z & alu_z, 1'b0, alu_h, 1'b0, alu_pv, alu_n, alu_c};
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq16.sv
// tb_alu_seq16: drives alu_seq16 with directed and random requests, provides a
// combinational 8-bit ALU, and checks every cycle against a whole-word model.
module tb_alu_seq16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_is16;
    logic [3:0]  in_f;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        ld_flags;
    logic [7:0]  flags_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_d;
    logic        out_err;
    logic [7:0]  flags;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [3:0]  alu_f;
    logic [7:0]  alu_d;
    logic        alu_s, alu_z, alu_h, alu_pv, alu_n, alu_c;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    logic [15:0] last_d;
    logic [7:0]  last_flags;
    logic        last_err;
    int          last_lat;

    alu_seq16 dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_is16(in_is16), .in_f(in_f),
        .in_a(in_a), .in_b(in_b), .ld_flags(ld_flags), .flags_in(flags_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_err(out_err),
        .flags(flags), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_f(alu_f),
        .alu_d(alu_d), .alu_s(alu_s), .alu_z(alu_z), .alu_h(alu_h), .alu_pv(alu_pv),
        .alu_n(alu_n), .alu_c(alu_c)
    );

    always #5 clk = ~clk;

    // 8-bit ALU: H is bit-3 carry of the internal adder, PV is overflow for
    // ADD/ADC/SUB/SBC and even parity otherwise, C for subtracts is a borrow.
    function automatic logic [13:0] alu8(input logic [3:0] f, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
        logic [8:0] t;
        logic [7:0] d, nb;
        logic c, h, v, n, arith;
        t = '0; d = '0; nb = ~b; c = 1'b0; h = 1'b0; v = 1'b0; n = 1'b0; arith = 1'b0;
        case (f)
            4'd0: begin d = b; c = cin; end
            4'd1: begin t = {1'b0, b} + 9'd1;          d = t[7:0]; c = t[8]; end
            4'd2: begin t = {1'b0, b} + {8'd0, cin};   d = t[7:0]; c = t[8]; end
            4'd3: begin t = {1'b0, b} - 9'd1;          d = t[7:0]; c = t[8]; n = 1'b1; end
            4'd4: begin t = {1'b0, b} - {8'd0, cin};   d = t[7:0]; c = t[8]; n = 1'b1; end
            4'd5, 4'd6: begin
                t = {1'b0, a} + {1'b0, b} + {8'd0, (f == 4'd6) & cin};
                d = t[7:0]; c = t[8]; h = a[4] ^ b[4] ^ t[4];
                v = (a[7] == b[7]) && (d[7] != a[7]); arith = 1'b1;
            end
            4'd7, 4'd8: begin
                t = {1'b0, a} + {1'b0, nb} + {8'd0, (f == 4'd7) | ~cin};
                d = t[7:0]; c = ~t[8]; h = a[4] ^ nb[4] ^ t[4];
                v = (a[7] != b[7]) && (d[7] != a[7]); n = 1'b1; arith = 1'b1;
            end
            4'd9:  d = a & b;
            4'd10: d = a | b;
            4'd11: d = a ^ b;
            4'd12: begin d = {cin, b[7:1]};  c = b[0]; end
            4'd13: begin d = {b[6:0], cin};  c = b[7]; end
            4'd14: begin d = {b[0], b[7:1]}; c = b[0]; end
            default: begin d = {b[6:0], b[7]}; c = b[7]; end
        endcase
        return {d, d[7], (d == 8'd0), h, arith ? v : ~^d, n, c};
    endfunction

    always_comb begin
        {alu_d, alu_s, alu_z, alu_h, alu_pv, alu_n, alu_c} = alu8(alu_f, alu_a, alu_b, alu_cin);
    end

    function automatic logic msb(input logic is16, input logic [31:0] x);
        return is16 ? x[15] : x[7];
    endfunction

    // Whole-operation reference: the operation is done on the full 8- or 16-bit
    // word at once; flags follow from the word result (S/PV from its top byte).
    function automatic void model_op(input logic is16, input logic [3:0] f,
                                     input logic [15:0] a, input logic [15:0] b,
                                     input logic cin,
                                     output logic [15:0] d, output logic [7:0] fl);
        logic [31:0] mask, av, bv, nb, t, r, x, cinw;
        logic [7:0]  hb;
        logic c, h, v, n, arith, pv;
        mask = is16 ? 32'h0000_FFFF : 32'h0000_00FF;
        av = {16'd0, a} & mask;
        bv = {16'd0, b} & mask;
        nb = ~bv & mask;
        cinw = {31'd0, cin};
        t = '0; r = '0; x = '0;
        c = 1'b0; h = 1'b0; v = 1'b0; n = 1'b0; arith = 1'b0;
        case (f)
            4'd0: begin r = bv; c = cin; end
            4'd1: begin t = bv + 32'd1; r = t & mask; c = is16 ? t[16] : t[8]; end
            4'd2: begin t = bv + cinw;  r = t & mask; c = is16 ? t[16] : t[8]; end
            4'd3: begin r = (bv - 32'd1) & mask; c = (bv == 32'd0); n = 1'b1; end
            4'd4: begin r = (bv - cinw) & mask;  c = cin && (bv == 32'd0); n = 1'b1; end
            4'd5, 4'd6: begin
                t = av + bv + ((f == 4'd6) ? cinw : 32'd0);
                r = t & mask; c = is16 ? t[16] : t[8];
                x = av ^ bv ^ t; h = is16 ? x[12] : x[4];
                v = (msb(is16, av) == msb(is16, bv)) && (msb(is16, r) != msb(is16, av));
                arith = 1'b1;
            end
            4'd7, 4'd8: begin
                t = av + nb + ((f == 4'd7) ? 32'd1 : (cin ? 32'd0 : 32'd1));
                r = t & mask; c = is16 ? ~t[16] : ~t[8];
                x = av ^ nb ^ t; h = is16 ? x[12] : x[4];
                v = (msb(is16, av) != msb(is16, bv)) && (msb(is16, r) != msb(is16, av));
                n = 1'b1; arith = 1'b1;
            end
            4'd9:  r = av & bv;
            4'd10: r = av | bv;
            4'd11: r = av ^ bv;
            4'd12: begin
                r = (is16 ? {16'd0, cin, 15'd0} : {24'd0, cin, 7'd0}) | (bv >> 1);
                c = bv[0];
            end
            4'd13: begin r = ((bv << 1) | cinw) & mask; c = msb(is16, bv); end
            4'd14: begin r = ((bv & 32'd1) << 7) | (bv >> 1); c = bv[0]; end
            default: begin r = ((bv << 1) | (bv >> 7)) & mask; c = bv[7]; end
        endcase
        hb = is16 ? r[15:8] : r[7:0];
        pv = arith ? v : ~^hb;
        d  = r[15:0];
        fl = {msb(is16, r), (r == 32'd0), 1'b0, h, 1'b0, pv, n, c};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level expectation: accepted requests appear after a fixed
    // latency and stay until taken; flags change only at load or completion.
    logic        m_idle = 1'b1;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] m_d = '0;
    logic [7:0]  m_flags = '0;
    logic [15:0] p_d = '0;
    logic [7:0]  p_flags = '0;
    int          m_wait = 0;
    logic [7:0]  fa;
    logic [15:0] pd;
    logic [7:0]  pf;

    always @(posedge clk) begin
        if (reset) begin
            m_idle <= 1'b1; m_valid <= 1'b0; m_err <= 1'b0;
            m_d <= '0; m_flags <= '0; m_wait <= 0;
        end else if (m_idle) begin
            fa = ld_flags ? (flags_in & 8'hD7) : m_flags;
            m_flags <= fa;
            if (in_valid) begin
                m_idle <= 1'b0;
                if (in_is16 && (in_f == 4'd14 || in_f == 4'd15)) begin
                    m_valid <= 1'b1; m_d <= in_a; m_err <= 1'b1;
                end else begin
                    model_op(in_is16, in_f, in_a, in_b, fa[0], pd, pf);
                    p_d <= pd; p_flags <= pf;
                    m_wait <= in_is16 ? 2 : 1;
                end
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_valid <= 1'b1; m_d <= p_d; m_err <= 1'b0; m_flags <= p_flags;
            end
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0; m_idle <= 1'b1;
        end
    end

    // Per-cycle comparison against the transaction model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, m_idle});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("flags", {24'd0, flags}, {24'd0, m_flags});
            if (m_valid) begin
                check("out_d", {16'd0, out_d}, {16'd0, m_d});
                check("out_err", {31'd0, out_err}, {31'd0, m_err});
            end
            if (m_idle || m_valid)
                check("alu_idle", {11'd0, alu_a, alu_b, alu_cin, alu_f}, 32'd0);
        end
    end

    task automatic run_op(input logic is16, input logic [3:0] f, input logic [15:0] a,
                          input logic [15:0] b, input logic ld, input logic [7:0] fin,
                          input int hold, input logic ld_mid);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        check("ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_is16 = is16; in_f = f; in_a = a; in_b = b;
        ld_flags = ld; flags_in = fin; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 16'($urandom); in_b = 16'($urandom); in_f = 4'($urandom_range(0, 15));
        in_is16 = 1'($urandom_range(0, 1));
        ld_flags = ld_mid;
        flags_in = ld_mid ? 8'hFF : fin;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; ld_flags = 1'b0; lat++;
        end
        check("valid_wait", {31'd0, out_valid}, 32'd1);
        ld_flags = 1'b0;
        last_d = out_d; last_flags = flags; last_err = out_err; last_lat = lat;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] md;
        logic [7:0]  mf;
        reset = 1'b1; in_valid = 1'b0; in_is16 = 1'b0; in_f = '0; in_a = '0; in_b = '0;
        ld_flags = 1'b0; flags_in = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_d", {16'd0, out_d}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_flags", {24'd0, flags}, 32'd0);
        check("rst_alu", {11'd0, alu_a, alu_b, alu_cin, alu_f}, 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Hand-computed pins on the reference model itself.
        model_op(1'b1, 4'd5, 16'h12FF, 16'h0001, 1'b0, md, mf);
        check("model_add16", {8'd0, md, mf}, {8'd0, 16'h1300, 8'h00});
        model_op(1'b1, 4'd7, 16'h0000, 16'h0001, 1'b0, md, mf);
        check("model_sub16", {8'd0, md, mf}, {8'd0, 16'hFFFF, 8'h83});
        model_op(1'b1, 4'd1, 16'h0000, 16'hFFFF, 1'b0, md, mf);
        check("model_inc16", {8'd0, md, mf}, {8'd0, 16'h0000, 8'h45});
        model_op(1'b1, 4'd13, 16'h0000, 16'h8001, 1'b0, md, mf);
        check("model_rl16", {8'd0, md, mf}, {8'd0, 16'h0002, 8'h05});
        model_op(1'b1, 4'd12, 16'h0000, 16'h8001, 1'b0, md, mf);
        check("model_rr16", {8'd0, md, mf}, {8'd0, 16'h4000, 8'h01});
        model_op(1'b0, 4'd6, 16'h0010, 16'h0020, 1'b1, md, mf);
        check("model_adc8", {8'd0, md, mf}, {8'd0, 16'h0031, 8'h00});

        // Directed cases with literal expectations on the DUT.
        run_op(1'b1, 4'd5, 16'h12FF, 16'h0001, 1'b0, 8'h00, 0, 1'b0);
        check("add16_d", {16'd0, last_d}, 32'h1300);
        check("add16_flags", {24'd0, last_flags}, 32'h00);
        check("add16_lat", last_lat, 3);
        run_op(1'b1, 4'd7, 16'h0000, 16'h0001, 1'b0, 8'h00, 0, 1'b0);
        check("sub16_d", {16'd0, last_d}, 32'hFFFF);
        check("sub16_flags", {24'd0, last_flags}, 32'h83);
        run_op(1'b1, 4'd1, 16'h0000, 16'hFFFF, 1'b0, 8'h00, 0, 1'b0);
        check("inc16_d", {16'd0, last_d}, 32'h0000);
        check("inc16_flags", {24'd0, last_flags}, 32'h45);
        run_op(1'b1, 4'd13, 16'h0000, 16'h8001, 1'b1, 8'h00, 0, 1'b0);
        check("rl16_d", {16'd0, last_d}, 32'h0002);
        check("rl16_flags", {24'd0, last_flags}, 32'h05);
        run_op(1'b1, 4'd12, 16'h0000, 16'h8001, 1'b1, 8'h00, 0, 1'b0);
        check("rr16_d", {16'd0, last_d}, 32'h4000);
        check("rr16_flags", {24'd0, last_flags}, 32'h01);
        run_op(1'b0, 4'd6, 16'h0010, 16'h0020, 1'b1, 8'h01, 0, 1'b0);
        check("adc8_d", {16'd0, last_d}, 32'h0031);
        check("adc8_flags", {24'd0, last_flags}, 32'h00);
        check("adc8_lat", last_lat, 2);
        run_op(1'b0, 4'd11, 16'h005A, 16'h000F, 1'b0, 8'h00, 4, 1'b0);
        check("hold_d", {16'd0, last_d}, 32'h0055);
        check("hold_flags", {24'd0, last_flags}, 32'h04);
        run_op(1'b0, 4'd5, 16'h0001, 16'h0001, 1'b0, 8'h00, 0, 1'b1);
        check("ldmid_d", {16'd0, last_d}, 32'h0002);
        check("ldmid_flags", {24'd0, last_flags}, 32'h00);
        run_op(1'b1, 4'd15, 16'hBEEF, 16'h1234, 1'b1, 8'hFF, 1, 1'b0);
        check("err_d", {16'd0, last_d}, 32'hBEEF);
        check("err_flag", {31'd0, last_err}, 32'd1);
        check("err_flags", {24'd0, last_flags}, 32'hD7);
        check("err_lat", last_lat, 1);

        // Reset while the second pass is in progress.
        in_valid = 1'b1; in_is16 = 1'b1; in_f = 4'd5; in_a = 16'h1111; in_b = 16'h2222;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstp2_in_ready", {31'd0, in_ready}, 32'd1);
        check("rstp2_out_valid", {31'd0, out_valid}, 32'd0);
        check("rstp2_flags", {24'd0, flags}, 32'd0);

        // Randomized traffic, including illegal rotates and coincident flag loads.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ld_flags = 1'b1; flags_in = 8'($urandom);
                @(posedge clk); #1;
                ld_flags = 1'b0;
            end
            run_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   16'($urandom), 16'($urandom),
                   ($urandom_range(0, 3) == 0), 8'($urandom),
                   $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
        end

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
